component_top3: RTL and testbench

//  Downstream consumer of the union_find stage. After union_find has settled (out_valid high),
//  it scans every node index and reads is_root/size through union_find's combinational read port.
//  It keeps the three largest root component sizes, sorted, and multiplies them.
//  The product is returned with a valid/ready handshake; this is the final answer of the circuit puzzle.

---
 rtl/component_top3.sv | 166 ++++++++++++++++
 tb/tb_component_top3.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/component_top3.sv
// Scans every union_find node once it has settled, keeps the three largest root sizes
// (top0 >= top1 >= top2) and returns their product. Define ROOT_COUNT_EN to add a root counter output.
module component_top3 #(
    parameter  int MAX_NODE_COUNT  = 2000,
    localparam int INDEX_BIT_WIDTH = $clog2(MAX_NODE_COUNT),
    localparam int RESULT_WIDTH    = 3 * INDEX_BIT_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    output logic [INDEX_BIT_WIDTH-1:0] uf_index,
    input  logic                       uf_valid,
    input  logic                       uf_is_root,
    input  logic [INDEX_BIT_WIDTH-1:0] uf_size,
    output logic                       busy,
    output logic                       result_valid,
    input  logic                       result_ready,
    output logic [RESULT_WIDTH-1:0]    result,
    output logic [INDEX_BIT_WIDTH-1:0] top0,
    output logic [INDEX_BIT_WIDTH-1:0] top1,
    output logic [INDEX_BIT_WIDTH-1:0] top2
`ifdef ROOT_COUNT_EN
    ,
    output logic [INDEX_BIT_WIDTH-1:0] root_count
`endif
);

    localparam int W  = INDEX_BIT_WIDTH;
    localparam int PW = 2 * INDEX_BIT_WIDTH;
    localparam logic [W-1:0] LAST_IDX = W'(MAX_NODE_COUNT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_UF,
        S_SCAN,
        S_MUL1,
        S_MUL2,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [W-1:0]            idx_q, idx_d;
    logic [W-1:0]            top0_q, top0_d;
    logic [W-1:0]            top1_q, top1_d;
    logic [W-1:0]            top2_q, top2_d;
    logic [PW-1:0]           prod_q, prod_d;
    logic [RESULT_WIDTH-1:0] result_q, result_d;
`ifdef ROOT_COUNT_EN
    logic [W-1:0]            rc_q, rc_d;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start) state_d = S_WAIT_UF;
            S_WAIT_UF: if (uf_valid) state_d = S_SCAN;
            S_SCAN:    if (uf_valid && (idx_q == LAST_IDX)) state_d = S_MUL1;
            S_MUL1:    state_d = S_MUL2;
            S_MUL2:    state_d = S_DONE;
            S_DONE:    if (result_ready) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy         = (state_q != S_IDLE);
        result_valid = (state_q == S_DONE);
    end

    // Datapath next-state: scan counter, sorted top-3 insertion, two-step product
    always_comb begin
        idx_d    = idx_q;
        top0_d   = top0_q;
        top1_d   = top1_q;
        top2_d   = top2_q;
        prod_d   = prod_q;
        result_d = result_q;
`ifdef ROOT_COUNT_EN
        rc_d     = rc_q;
`endif
        case (state_q)
            S_IDLE: begin
                idx_d = '0;
                if (start) begin
                    top0_d = '0;
                    top1_d = '0;
                    top2_d = '0;
`ifdef ROOT_COUNT_EN
                    rc_d   = '0;
`endif
                end
            end
            S_WAIT_UF: idx_d = '0;
            S_SCAN: begin
                if (uf_valid) begin
                    idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
                    if (uf_is_root) begin
                        // Strict compares: a tie lands below the existing equal entry.
                        if (uf_size > top0_q) begin
                            top2_d = top1_q;
                            top1_d = top0_q;
                            top0_d = uf_size;
                        end else if (uf_size > top1_q) begin
                            top2_d = top1_q;
                            top1_d = uf_size;
                        end else if (uf_size > top2_q) begin
                            top2_d = uf_size;
                        end
`ifdef ROOT_COUNT_EN
                        if (rc_q != '1) rc_d = rc_q + 1'b1;
`endif
                    end
                end
            end
            S_MUL1: prod_d = PW'(top0_q) * PW'(top1_q);
            S_MUL2: result_d = RESULT_WIDTH'(prod_q) * RESULT_WIDTH'(top2_q);
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q    <= '0;
            top0_q   <= '0;
            top1_q   <= '0;
            top2_q   <= '0;
            prod_q   <= '0;
            result_q <= '0;
`ifdef ROOT_COUNT_EN
            rc_q     <= '0;
`endif
        end else begin
            idx_q    <= idx_d;
            top0_q   <= top0_d;
            top1_q   <= top1_d;
            top2_q   <= top2_d;
            prod_q   <= prod_d;
            result_q <= result_d;
`ifdef ROOT_COUNT_EN
            rc_q     <= rc_d;
`endif
        end
    end

    assign uf_index = idx_q;
    assign result   = result_q;
    assign top0     = top0_q;
    assign top1     = top1_q;
    assign top2     = top2_q;
`ifdef ROOT_COUNT_EN
    assign root_count = rc_q;
`endif

endmodule

// File: tb/tb_component_top3.sv
// Self-checking bench for component_top3: an 8-node instance for directed and random scans,
// and a 2000-node instance for the large product and DONE back-pressure.
module tb_component_top3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // 8-node instance
    logic        start_s, valid_s, ready_s, root_s, busy_s, rv_s;
    logic [2:0]  index_s, size_s, t0_s, t1_s, t2_s;
    logic [8:0]  result_s;
    bit          root_s_arr[8];
    int          size_s_arr[8];
    assign root_s = root_s_arr[index_s];
    assign size_s = 3'(size_s_arr[index_s]);
`ifdef ROOT_COUNT_EN
    logic [2:0]  rc_s;
`endif

    component_top3 #(.MAX_NODE_COUNT(8)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(start_s), .uf_index(index_s),
        .uf_valid(valid_s), .uf_is_root(root_s), .uf_size(size_s),
        .busy(busy_s), .result_valid(rv_s), .result_ready(ready_s),
        .result(result_s), .top0(t0_s), .top1(t1_s), .top2(t2_s)
`ifdef ROOT_COUNT_EN
        , .root_count(rc_s)
`endif
    );

    // 2000-node instance
    logic        start_l, valid_l, ready_l, root_l, busy_l, rv_l;
    logic [10:0] index_l, size_l, t0_l, t1_l, t2_l;
    logic [32:0] result_l;
    bit          root_l_arr[2048];
    int          size_l_arr[2048];
    assign root_l = root_l_arr[index_l];
    assign size_l = 11'(size_l_arr[index_l]);
`ifdef ROOT_COUNT_EN
    logic [10:0] rc_l;
`endif

    component_top3 #(.MAX_NODE_COUNT(2000)) dut_l (
        .clk(clk), .rst_n(rst_n), .start(start_l), .uf_index(index_l),
        .uf_valid(valid_l), .uf_is_root(root_l), .uf_size(size_l),
        .busy(busy_l), .result_valid(rv_l), .result_ready(ready_l),
        .result(result_l), .top0(t0_l), .top1(t1_l), .top2(t2_l)
`ifdef ROOT_COUNT_EN
        , .root_count(rc_l)
`endif
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: the three largest root sizes of the multiset, zero-padded.
    function automatic void top3(input int q_in[$], output longint a, output longint b, output longint c);
        int q[$];
        q = q_in;
        q.rsort();
        while (q.size() < 3) q.push_back(0);
        a = q[0];
        b = q[1];
        c = q[2];
    endfunction

    // Entered just after a negedge with the 8-node DUT in IDLE.
    task automatic run_small(input string name, input int stall_at, input int stall_len);
        int     q[$];
        longint e0, e1, e2, ecnt;
        int     lat, rem;
        bit     armed;
        for (int i = 0; i < 8; i++) if (root_s_arr[i]) q.push_back(size_s_arr[i]);
        top3(q, e0, e1, e2);
        ecnt = (q.size() > 7) ? 7 : q.size();

        valid_s = 1'b0;
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        check({name, "_busy_wait"}, busy_s, 1);
        check({name, "_idx_wait"}, index_s, 0);
        @(negedge clk);
        valid_s = 1'b1;
        @(posedge clk);
        lat   = 0;
        rem   = stall_len;
        armed = (stall_at >= 0);
        while (lat < 60) begin
            @(negedge clk);
            if (rv_s) break;
            if (armed && index_s == 3'(stall_at)) begin
                if (rem > 0) begin
                    valid_s = 1'b0;
                    rem--;
                end else begin
                    valid_s = 1'b1;
                    armed   = 1'b0;
                end
            end
            @(posedge clk);
            lat++;
        end
        valid_s = 1'b1;
        check({name, "_latency"}, lat, 10 + ((stall_at >= 0) ? stall_len : 0));
        check({name, "_rv"}, rv_s, 1);
        check({name, "_top0"}, t0_s, e0);
        check({name, "_top1"}, t1_s, e1);
        check({name, "_top2"}, t2_s, e2);
        check({name, "_result"}, result_s, e0 * e1 * e2);
`ifdef ROOT_COUNT_EN
        check({name, "_root_count"}, rc_s, ecnt);
`endif
        $display("scan %s: top=%0d/%0d/%0d result=%0d roots=%0d latency=%0d",
                 name, t0_s, t1_s, t2_s, result_s, ecnt, lat);
        ready_s = 1'b1;
        @(negedge clk);
        ready_s = 1'b0;
        check({name, "_rv_drop"}, rv_s, 0);
        check({name, "_idle"}, busy_s, 0);
        check({name, "_result_kept"}, result_s, e0 * e1 * e2);
    endtask

    task automatic clear_small();
        for (int i = 0; i < 8; i++) begin
            root_s_arr[i] = 1'b0;
            size_s_arr[i] = $urandom_range(0, 7);
        end
    endtask

    initial begin
        int     q[$];
        longint e0, e1, e2;
        int     cnt, extra_idx;

        rst_n = 1'b0;
        start_s = 1'b0; valid_s = 1'b0; ready_s = 1'b0;
        start_l = 1'b0; valid_l = 1'b0; ready_l = 1'b0;
        clear_small();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("reset_busy", busy_s, 0);
        check("reset_rv", rv_s, 0);
        check("reset_idx", index_s, 0);
        check("reset_result", result_s, 0);
        check("reset_top0", t0_s, 0);
        check("reset_top2", t2_s, 0);

        // Case 1: roots {3,1,4} at 0,2,5
        clear_small();
        root_s_arr[0] = 1; size_s_arr[0] = 3;
        root_s_arr[2] = 1; size_s_arr[2] = 1;
        root_s_arr[5] = 1; size_s_arr[5] = 4;
        run_small("case1", -1, 0);
        // Case 4: same with a 3-cycle stall at index 4
        run_small("case4_stall", 4, 3);

        // Case 2: four equal roots
        clear_small();
        root_s_arr[1] = 1; size_s_arr[1] = 2;
        root_s_arr[3] = 1; size_s_arr[3] = 2;
        root_s_arr[4] = 1; size_s_arr[4] = 2;
        root_s_arr[6] = 1; size_s_arr[6] = 2;
        run_small("case2_ties", -1, 0);

        // Case 3: only two roots
        clear_small();
        root_s_arr[2] = 1; size_s_arr[2] = 5;
        root_s_arr[7] = 1; size_s_arr[7] = 3;
        run_small("case3_two", -1, 0);

        // Case 5: reset during SCAN at index 3
        clear_small();
        root_s_arr[0] = 1; size_s_arr[0] = 6;
        root_s_arr[1] = 1; size_s_arr[1] = 5;
        root_s_arr[2] = 1; size_s_arr[2] = 7;
        start_s = 1'b1; valid_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        cnt = 0;
        while (index_s != 3'd3 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check("case5_reached_idx3", index_s, 3);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("case5_busy", busy_s, 0);
        check("case5_rv", rv_s, 0);
        check("case5_top0", t0_s, 0);
        check("case5_top1", t1_s, 0);
        check("case5_idx", index_s, 0);
        run_small("case5_fresh", -1, 0);

        // Randomized scans, some with stalls
        for (int r = 0; r < 12; r++) begin
            clear_small();
            for (int i = 0; i < 8; i++) root_s_arr[i] = 1'($urandom_range(0, 1));
            if (r % 3 == 0) run_small($sformatf("rand%0d", r), $urandom_range(0, 7), $urandom_range(1, 3));
            else            run_small($sformatf("rand%0d", r), -1, 0);
        end

        // Case 6: 2000 nodes, sizes 1000/600/400 plus random smaller roots, back-pressure in DONE
        for (int i = 0; i < 2048; i++) begin
            root_l_arr[i] = 1'b0;
            size_l_arr[i] = 0;
        end
        root_l_arr[10] = 1;   size_l_arr[10] = 600;
        root_l_arr[900] = 1;  size_l_arr[900] = 1000;
        root_l_arr[1999] = 1; size_l_arr[1999] = 400;
        for (int k = 0; k < 20; k++) begin
            extra_idx = $urandom_range(11, 899);
            root_l_arr[extra_idx] = 1;
            size_l_arr[extra_idx] = $urandom_range(0, 399);
        end
        for (int i = 0; i < 2000; i++) if (root_l_arr[i]) q.push_back(size_l_arr[i]);
        top3(q, e0, e1, e2);
        valid_l = 1'b1;
        start_l = 1'b1;
        cnt = 0;
        while (cnt < 2100) begin
            @(negedge clk);
            start_l = 1'b0;
            cnt++;
            if (rv_l) break;
        end
        check("case6_latency", cnt, 2004);
        for (int k = 0; k < 5; k++) begin
            start_l = 1'b1;
            @(negedge clk);
            check("case6_hold_rv", rv_l, 1);
            check("case6_hold_result", result_l, 240000000);
            check("case6_model_result", result_l, e0 * e1 * e2);
        end
        start_l = 1'b0;
        check("case6_top0", t0_l, 1000);
        check("case6_top1", t1_l, 600);
        check("case6_top2", t2_l, 400);
`ifdef ROOT_COUNT_EN
        check("case6_root_count", rc_l, q.size());
`endif
        $display("scan case6: top=%0d/%0d/%0d result=%0d", t0_l, t1_l, t2_l, result_l);
        ready_l = 1'b1;
        @(negedge clk);
        ready_l = 1'b0;
        check("case6_idle", busy_l, 0);
        check("case6_rv_drop", rv_l, 0);
        @(negedge clk);
        check("case6_stay_idle", busy_l, 0);
        check("case6_result_kept", result_l, 240000000);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
